mem_wb_stage: RTL

MEM/WB pipeline register and load-data formatter between the data-memory stage and the register file write port. Captures the ALU result, raw memory read word and write-back control from MEM. Aligns and sign/zero-extends load data. Presents write enable, destination, load data, ALU result and source-select to the register file one cycle later. Also supplies a forwarding value and a retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 43 ++++
 rtl/mem_wb_stage.sv | 87 ++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: MEM-side capture inputs, pipeline control and
// the write-back outputs presented to the register file and forwarding unit.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_ld_size;
    logic              mem_ld_unsigned;

    logic              wb_enable;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_write_data;
    logic [DATA_W-1:0] wb_result;
    logic              wb_muxcontrol;
    logic              wb_fwd_valid;
    logic [DATA_W-1:0] wb_fwd_data;
    logic [CNT_W-1:0]  retire_count;

    // Pipeline side: drives MEM values and control, observes write-back.
    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_to_reg, mem_dest,
               mem_alu_result, mem_rdata, mem_ld_size, mem_ld_unsigned,
        input  wb_enable, wb_reg, wb_write_data, wb_result, wb_muxcontrol,
               wb_fwd_valid, wb_fwd_data, retire_count
    );

    // Stage side.
    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_to_reg, mem_dest,
               mem_alu_result, mem_rdata, mem_ld_size, mem_ld_unsigned,
        output wb_enable, wb_reg, wb_write_data, wb_result, wb_muxcontrol,
               wb_fwd_valid, wb_fwd_data, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load alignment and extension,
// register-0 write suppression, forwarding value and retired-instruction count.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);
    logic [1:0]        off;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_data;

    logic              valid_q;
    logic              reg_write_q;
    logic              mux_q;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    assign off = bus.mem_alu_result[1:0];

    // Select the addressed byte/half (lane 0 is the most significant) and extend.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ld_data  = bus.mem_rdata;
        case (bus.mem_ld_size)
            2'b00: begin
                case (off)
                    2'd0:    byte_sel = bus.mem_rdata[31:24];
                    2'd1:    byte_sel = bus.mem_rdata[23:16];
                    2'd2:    byte_sel = bus.mem_rdata[15:8];
                    default: byte_sel = bus.mem_rdata[7:0];
                endcase
                ld_data = {{(DATA_W-8){~bus.mem_ld_unsigned & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                // off[0] is ignored; misaligned halves trap before reaching here.
                half_sel = off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
                ld_data  = {{(DATA_W-16){~bus.mem_ld_unsigned & half_sel[15]}}, half_sel};
            end
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // Pipeline register: reset > flush > stall > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mux_q       <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q     <= bus.mem_valid;
            reg_write_q <= bus.mem_reg_write;
            mux_q       <= ~bus.mem_to_reg;
            dest_q      <= bus.mem_dest;
            result_q    <= bus.mem_alu_result;
            wdata_q     <= ld_data;
            if (bus.mem_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Write-back outputs are pure decodes of the registered state.
    always_comb begin
        bus.wb_enable     = valid_q & reg_write_q & (dest_q != '0);
        bus.wb_reg        = dest_q;
        bus.wb_write_data = wdata_q;
        bus.wb_result     = result_q;
        bus.wb_muxcontrol = mux_q;
        bus.wb_fwd_valid  = valid_q & reg_write_q & (dest_q != '0);
        bus.wb_fwd_data   = mux_q ? result_q : wdata_q;
        bus.retire_count  = cnt_q;
    end
endmodule
